// File: rtl/s_arith_pkg.sv
// Shared arithmetic helpers: constant clog2, accumulator width derivation and
// two's complement saturation limits for a given word length.
package s_arith_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r++;
        end
        return r;
    endfunction

    // Product width plus growth over LEN terms plus one guard bit.
    function automatic int unsigned acc_wl(input int unsigned inwl, input int unsigned len);
        return 2 * inwl + clog2(len) + 1;
    endfunction

    function automatic logic signed [63:0] sat_max(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/s_mult.sv
// Combinational full-precision signed multiplier.
module s_mult #(
    parameter int unsigned IN1WL = 8,
    parameter int unsigned IN2WL = 8
) (
    input  logic signed [IN1WL-1:0]       IN1,
    input  logic signed [IN2WL-1:0]       IN2,
    output logic signed [IN1WL+IN2WL-1:0] OUT
);

    localparam int unsigned OWL = IN1WL + IN2WL;

    assign OUT = OWL'(IN1) * OWL'(IN2);

endmodule

// File: rtl/s_sat.sv
// Combinational signed saturation from INWL down to OUTWL bits; SAT flags a clip.
module s_sat
    import s_arith_pkg::*;
#(
    parameter int unsigned INWL  = 20,
    parameter int unsigned OUTWL = 16
) (
    input  logic signed [INWL-1:0]  IN,
    output logic signed [OUTWL-1:0] OUT,
    output logic                    SAT
);

    localparam logic signed [INWL-1:0]  MAX_IN  = INWL'(sat_max(OUTWL));
    localparam logic signed [INWL-1:0]  MIN_IN  = INWL'(sat_min(OUTWL));
    localparam logic signed [OUTWL-1:0] MAX_OUT = OUTWL'(sat_max(OUTWL));
    localparam logic signed [OUTWL-1:0] MIN_OUT = OUTWL'(sat_min(OUTWL));

    always_comb begin
        OUT = IN[OUTWL-1:0];
        SAT = 1'b0;
        if (IN > MAX_IN) begin
            OUT = MAX_OUT;
            SAT = 1'b1;
        end else if (IN < MIN_IN) begin
            OUT = MIN_OUT;
            SAT = 1'b1;
        end
    end

endmodule

// File: rtl/s_mac_acc.sv
// Signed multiply-accumulate: registers each product, sums LEN of them per frame
// and emits one saturated result per frame over valid/ready handshakes.
module s_mac_acc
    import s_arith_pkg::*;
#(
    parameter int unsigned INWL  = 8,
    parameter int unsigned LEN   = 4,
    parameter int unsigned OUTWL = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    IN_VLD,
    output logic                    IN_RDY,
    input  logic signed [INWL-1:0]  IN1,
    input  logic signed [INWL-1:0]  IN2,
    output logic                    OUT_VLD,
    input  logic                    OUT_RDY,
    output logic signed [OUTWL-1:0] OUT,
    output logic                    OUT_SAT
);

    localparam int unsigned ACCWL = acc_wl(INWL, LEN);
    localparam int unsigned PWL   = 2 * INWL;
    localparam int unsigned CNTWL = (LEN > 1) ? clog2(LEN) : 1;
    localparam logic [CNTWL-1:0] CNT_LAST = CNTWL'(LEN - 1);

    logic signed [PWL-1:0]   prod;
    logic signed [PWL-1:0]   p_reg;
    logic                    p_vld;
    logic [CNTWL-1:0]        cnt;
    logic signed [ACCWL-1:0] acc;
    logic signed [ACCWL-1:0] acc_base;
    logic signed [ACCWL-1:0] sum;
    logic signed [OUTWL-1:0] sat_val;
    logic                    sat_flag;
    logic signed [OUTWL-1:0] out_reg;
    logic                    out_sat_reg;
    logic                    out_vld_reg;
    logic                    last;
    logic                    take;
    logic                    in_hs;

    s_mult #(
        .IN1WL (INWL),
        .IN2WL (INWL)
    ) u_mult (
        .IN1 (IN1),
        .IN2 (IN2),
        .OUT (prod)
    );

    s_sat #(
        .INWL  (ACCWL),
        .OUTWL (OUTWL)
    ) u_sat (
        .IN  (sum),
        .OUT (sat_val),
        .SAT (sat_flag)
    );

    always_comb begin
        last     = (cnt == CNT_LAST);
        // The last product of a frame must wait while the previous result is held.
        take     = p_vld && !(last && out_vld_reg && !OUT_RDY);
        IN_RDY   = !RST && (!p_vld || take);
        in_hs    = IN_VLD && IN_RDY;
        acc_base = (cnt == '0) ? '0 : acc;
        sum      = acc_base + ACCWL'(p_reg);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            p_reg       <= '0;
            p_vld       <= 1'b0;
            cnt         <= '0;
            acc         <= '0;
            out_reg     <= '0;
            out_sat_reg <= 1'b0;
            out_vld_reg <= 1'b0;
        end else begin
            if (in_hs) begin
                p_reg <= prod;
                p_vld <= 1'b1;
            end else if (take) begin
                p_vld <= 1'b0;
            end

            if (take && last) begin
                out_reg     <= sat_val;
                out_sat_reg <= sat_flag;
                out_vld_reg <= 1'b1;
                cnt         <= '0;
            end else begin
                if (take) begin
                    acc <= sum;
                    cnt <= cnt + 1'b1;
                end
                if (out_vld_reg && OUT_RDY) begin
                    out_vld_reg <= 1'b0;
                end
            end
        end
    end

    assign OUT     = out_reg;
    assign OUT_SAT = out_sat_reg;
    assign OUT_VLD = out_vld_reg;

endmodule

// File: tb/tb_s_mac_acc.sv
// Scoreboard bench for s_mac_acc: a frame-level model pushes expected results on
// input handshakes; the monitor pops and compares them on output handshakes.
module tb_s_mac_acc;

    localparam int INWL  = 8;
    localparam int LEN   = 4;
    localparam int OUTWL = 16;
    localparam longint OMAX = (64'sd1 <<< (OUTWL - 1)) - 1;
    localparam longint OMIN = -(64'sd1 <<< (OUTWL - 1));

    logic                    CLK = 1'b0;
    logic                    RST;
    logic                    IN_VLD;
    logic                    IN_RDY;
    logic signed [INWL-1:0]  IN1;
    logic signed [INWL-1:0]  IN2;
    logic                    OUT_VLD;
    logic                    OUT_RDY;
    logic signed [OUTWL-1:0] OUT;
    logic                    OUT_SAT;

    always #5 CLK = ~CLK;

    s_mac_acc #(
        .INWL  (INWL),
        .LEN   (LEN),
        .OUTWL (OUTWL)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .IN_VLD  (IN_VLD),
        .IN_RDY  (IN_RDY),
        .IN1     (IN1),
        .IN2     (IN2),
        .OUT_VLD (OUT_VLD),
        .OUT_RDY (OUT_RDY),
        .OUT     (OUT),
        .OUT_SAT (OUT_SAT)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard and frame model
    longint exp_out[$];
    logic   exp_sat[$];
    longint m_acc = 0;
    int     m_cnt = 0;
    int     cyc = 0;
    int     hs_cnt = 0;
    int     last_hs_cyc = 0;
    int     vld_cnt = 0;
    int     vld_cyc[$];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (RST) begin
            m_acc = 0;
            m_cnt = 0;
            exp_out.delete();
            exp_sat.delete();
        end else begin
            if (OUT_VLD) begin
                vld_cnt++;
                vld_cyc.push_back(cyc);
            end
            if (OUT_VLD && OUT_RDY) begin
                if (exp_out.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    check("out", OUT, exp_out.pop_front());
                    check("out_sat", OUT_SAT, exp_sat.pop_front());
                end
            end
            if (IN_VLD && IN_RDY) begin
                hs_cnt++;
                last_hs_cyc = cyc;
                m_acc += longint'(IN1) * longint'(IN2);
                m_cnt++;
                if (m_cnt == LEN) begin
                    if (m_acc > OMAX) begin
                        exp_out.push_back(OMAX);
                        exp_sat.push_back(1'b1);
                    end else if (m_acc < OMIN) begin
                        exp_out.push_back(OMIN);
                        exp_sat.push_back(1'b1);
                    end else begin
                        exp_out.push_back(m_acc);
                        exp_sat.push_back(1'b0);
                    end
                    m_acc = 0;
                    m_cnt = 0;
                end
            end
        end
    end

    // Present one pair and return just after the edge that accepts it.
    task automatic send(input int a, input int b);
        int t;
        t = 0;
        IN_VLD = 1'b1;
        IN1 = INWL'(a);
        IN2 = INWL'(b);
        while (!IN_RDY && t < 50) begin
            @(posedge CLK);
            #1;
            t++;
        end
        if (t >= 50) check("send_timeout", 1, 0);
        @(posedge CLK);
        #1;
        IN_VLD = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_out.size() != 0 || OUT_VLD) && t < 50) begin
            @(posedge CLK);
            #1;
            t++;
        end
        if (t >= 50) check("drain_timeout", 1, 0);
        repeat (3) @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [OUTWL-1:0] held;
        int c0;
        int h0;
        int t;
        int unstable;

        RST = 1'b1;
        IN_VLD = 1'b0;
        IN1 = '0;
        IN2 = '0;
        OUT_RDY = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_in_rdy", IN_RDY, 0);
        check("rst_out_vld", OUT_VLD, 0);
        check("rst_out", OUT, 0);
        check("rst_out_sat", OUT_SAT, 0);
        RST = 1'b0;
        #1;
        check("post_rst_in_rdy", IN_RDY, 1);

        // Single frame: -70, one-cycle pulse two edges after last handshake
        vld_cnt = 0;
        vld_cyc.delete();
        send(3, 4);
        send(-5, 6);
        send(7, -8);
        send(2, 2);
        drain();
        check("single_pulse_cycles", vld_cnt, 1);
        check("single_latency", (vld_cyc.size() > 0) ? vld_cyc[0] - last_hs_cyc : -1, 2);

        // Saturation both directions
        for (int i = 0; i < LEN; i++) send(-128, -128);
        for (int i = 0; i < LEN; i++) send(-128, 127);
        drain();

        // Streaming: back-to-back, no bubbles, pulses LEN cycles apart
        vld_cyc.delete();
        c0 = cyc;
        for (int i = 0; i < 2 * LEN; i++) send(1, 1);
        check("stream_cycles", cyc - c0, 2 * LEN);
        drain();
        check("stream_pulses", vld_cyc.size(), 2);
        check("stream_spacing", (vld_cyc.size() == 2) ? vld_cyc[1] - vld_cyc[0] : -1, LEN);

        // Backpressure: hold first result, next frame stalls on its last product
        send(1, 2);
        send(3, 4);
        send(5, 6);
        send(7, 8);
        OUT_RDY = 1'b0;
        t = 0;
        while (!OUT_VLD && t < 20) begin
            @(posedge CLK);
            #1;
            t++;
        end
        check("bp_first_vld", OUT_VLD, 1);
        check("bp_first_out", OUT, 100);
        held = OUT;
        h0 = hs_cnt;
        unstable = 0;
        for (int k = 0; k < 10; k++) begin
            IN_VLD = 1'b1;
            IN1 = INWL'(k + 1);
            IN2 = INWL'(-3);
            @(posedge CLK);
            #1;
            if (OUT !== held || OUT_VLD !== 1'b1) unstable++;
        end
        IN_VLD = 1'b0;
        check("bp_handshakes", hs_cnt - h0, LEN);
        check("bp_in_rdy_low", IN_RDY, 0);
        check("bp_out_unstable", unstable, 0);
        OUT_RDY = 1'b1;
        @(posedge CLK);
        #1;
        check("bp_release_vld", OUT_VLD, 1);
        check("bp_release_out", OUT, -30);
        drain();

        // Reset mid-frame discards the partial sum
        send(5, 5);
        send(5, 5);
        RST = 1'b1;
        #1;
        check("midrst_in_rdy_comb", IN_RDY, 0);
        @(posedge CLK);
        #1;
        check("midrst_in_rdy", IN_RDY, 0);
        check("midrst_out_vld", OUT_VLD, 0);
        check("midrst_out", OUT, 0);
        check("midrst_out_sat", OUT_SAT, 0);
        RST = 1'b0;
        #1;
        check("midrst_release_rdy", IN_RDY, 1);
        vld_cyc.delete();
        for (int i = 0; i < LEN; i++) send(1, 1);
        drain();
        check("midrst_results", vld_cyc.size(), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
